// File: rtl/fixed_pkg.sv
// Shared Q16.16 fixed-point types and constants used by the vector arithmetic blocks.
package fixed_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam logic [Q_W-1:0] Q_ONE = 32'h0001_0000;
  localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

  typedef logic signed [Q_W-1:0] q16_t;
  typedef q16_t [2:0] vec3_t;

endpackage

// File: rtl/udiv_core.sv
// Unsigned radix-2 restoring divider.
// The first iteration is folded into the load cycle, so q is final ITER cycles after start.
module udiv_core #(
  parameter int NW   = 48,
  parameter int DW   = 32,
  parameter int ITER = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] q
);

  localparam int CW = $clog2(ITER);

  logic [DW:0]   rem;
  logic [NW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          load;
  logic [DW:0]   src_rem;
  logic [NW-1:0] src_quo;
  logic [DW:0]   shifted;
  logic          fits;
  logic [DW:0]   nxt_rem;
  logic [NW-1:0] nxt_quo;

  assign load = start && !busy;
  assign q    = quo;

  always_comb begin
    src_rem = load ? '0 : rem;
    src_quo = load ? n : quo;
    shifted = {src_rem[DW-1:0], src_quo[NW-1]};
    fits    = (shifted >= {1'b0, d});
    nxt_rem = fits ? (shifted - {1'b0, d}) : shifted;
    nxt_quo = {src_quo[NW-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rem  <= nxt_rem;
        quo  <= nxt_quo;
        cnt  <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= nxt_rem;
        quo <= nxt_quo;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(ITER - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vec_div_scalar.sv
// Divides a signed Q16.16 vector by a signed Q16.16 scalar, one component at a time,
// through a shared unsigned divider; handles signs, saturation and divide-by-zero.
module vec_div_scalar
  import fixed_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int ITER = W + FRAC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  vec3_t x,
  input  q16_t  a,
  output logic  out_valid,
  input  logic  out_ready,
  output vec3_t out,
  output logic  div_zero,
  output logic  overflow
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_nxt;
  vec3_t           x_reg;
  logic [W-1:0]    a_mag;
  logic            a_neg;
  logic [1:0]      idx;
  logic            first;

  logic            core_start, core_busy, core_done;
  logic [W+FRAC-1:0] core_q;
  logic [1:0]      src_idx;
  q16_t            x_src;
  logic [W-1:0]    x_mag;

  q16_t            x_cur;
  logic            res_neg;
  logic            sat;
  q16_t            res;

  // Operand for the next core start: the following component when restarting on done.
  always_comb begin
    src_idx = (core_done && idx != 2'd2) ? idx + 2'd1 : idx;
    x_src   = x_reg[src_idx];
    x_mag   = x_src[W-1] ? W'(-x_src) : W'(x_src);
  end

  assign core_start = (state == DIV) && (first || (core_done && idx != 2'd2));

  udiv_core #(.NW(W + FRAC), .DW(W), .ITER(ITER)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .n     ({x_mag, {FRAC{1'b0}}}),
    .d     (a_mag),
    .busy  (core_busy),
    .done  (core_done),
    .q     (core_q)
  );

  // Sign restore and saturation of the finished quotient for component idx.
  always_comb begin
    x_cur   = x_reg[idx];
    res_neg = x_cur[W-1] ^ a_neg;
    sat     = 1'b0;
    res     = '0;
    if (div_zero) begin
      if (x_cur == '0)      res = '0;
      else if (x_cur[W-1])  res = Q_MIN;
      else                  res = Q_MAX;
    end else if (!res_neg) begin
      if (|core_q[W+FRAC-1:W-1]) begin
        res = Q_MAX;
        sat = 1'b1;
      end else begin
        res = core_q[W-1:0];
      end
    end else begin
      if ((|core_q[W+FRAC-1:W]) || (core_q[W-1] && (|core_q[W-2:0]))) begin
        res = Q_MIN;
        sat = 1'b1;
      end else begin
        res = -core_q[W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DIV;
      DIV:     if (core_done && idx == 2'd2) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x_reg    <= '0;
      a_mag    <= '0;
      a_neg    <= 1'b0;
      idx      <= '0;
      first    <= 1'b0;
      out      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      first <= 1'b0;
      if (state == IDLE && in_valid) begin
        x_reg    <= x;
        a_mag    <= a[W-1] ? W'(-a) : W'(a);
        a_neg    <= a[W-1];
        div_zero <= (a == '0);
        overflow <= 1'b0;
        idx      <= '0;
        first    <= 1'b1;
      end else if (state == DIV && core_done) begin
        out[idx] <= res;
        if (sat) overflow <= 1'b1;
        if (idx != 2'd2) idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_vec_div_scalar.sv
// Directed table-driven bench for vec_div_scalar with hand-computed Q16.16 results,
// plus backpressure and mid-operation reset sequences.
module tb_vec_div_scalar;
  import fixed_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] x0, x1, x2, a;
    logic [31:0] e0, e1, e2;
    logic        dz, ov;
  } vec_rec_t;

  localparam int LAT = 145;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  vec3_t x;
  q16_t  a;
  logic  out_valid;
  logic  out_ready;
  vec3_t out;
  logic  div_zero;
  logic  overflow;

  int total = 0;
  int bad   = 0;

  vec_rec_t tbl[5];

  vec_div_scalar dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present operands for one accepting edge, then count cycles until out_valid.
  task automatic applyStimulus(input vec_rec_t v, output int lat);
    x[0] = v.x0;
    x[1] = v.x1;
    x[2] = v.x2;
    a = v.a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input vec_rec_t v, input int lat);
    checkOutput({v.name, "_lat"}, 32'(lat), 32'(LAT));
    checkOutput({v.name, "_out0"}, out[0], v.e0);
    checkOutput({v.name, "_out1"}, out[1], v.e1);
    checkOutput({v.name, "_out2"}, out[2], v.e2);
    checkOutput({v.name, "_dz"}, 32'(div_zero), 32'(v.dz));
    checkOutput({v.name, "_ov"}, 32'(overflow), 32'(v.ov));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vec3_t held;
    logic  held_dz, held_ov;

    tbl[0] = '{"basic", 32'h0003_0000, 32'hFFFE_8000, 32'h0000_8000, 32'h0002_0000,
               32'h0001_8000, 32'hFFFF_4000, 32'h0000_4000, 1'b0, 1'b0};
    tbl[1] = '{"trunc", 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_0000,
               32'h0000_5555, 32'hFFFF_AAAB, 32'h0000_0000, 1'b0, 1'b0};
    tbl[2] = '{"divzero", 32'h0005_0000, 32'hFFFB_0000, 32'h0000_0000, 32'h0000_0000,
               32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{"ovf_small", 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0100,
               32'h7FFF_FFFF, 32'h8000_0000, 32'h0100_0000, 1'b0, 1'b1};
    tbl[4] = '{"ovf_neg1", 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_0000,
               32'h8001_0000, 32'h7FFF_FFFF, 32'hFFFF_0000, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    a = '0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out0", out[0], 32'd0);
    checkOutput("rst_dz", 32'(div_zero), 32'd0);
    checkOutput("rst_ov", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i], lat);
      checkResult(tbl[i], lat);
      handshake();
      checkOutput({tbl[i].name, "_ready_after"}, 32'(in_ready), 32'd1);
    end

    $display("[TB] backpressure sequence");
    applyStimulus(tbl[0], lat);
    checkResult(tbl[0], lat);
    held = out;
    held_dz = div_zero;
    held_ov = overflow;
    x[0] = 32'h0009_0000;
    a = 32'h0001_0000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_stable", {out != held, div_zero != held_dz, overflow != held_ov,
                  out_valid, in_ready}, 32'b00010);
    end
    in_valid = 1'b0;
    handshake();
    checkOutput("bp_ready_after", 32'(in_ready), 32'd1);
    checkOutput("bp_valid_after", 32'(out_valid), 32'd0);
    checkOutput("bp_out_held", out[1], 32'hFFFF_4000);
    @(posedge clk);
    #1;
    checkOutput("bp_not_accepted", 32'(in_ready), 32'd1);

    $display("[TB] reset mid-operation sequence");
    x[0] = 32'h0003_0000;
    x[1] = 32'h0003_0000;
    x[2] = 32'h0003_0000;
    a = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out", 32'(out[0] | out[1] | out[2]), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_rst_ready_rel", 32'(in_ready), 32'd1);
    applyStimulus(tbl[1], lat);
    checkResult(tbl[1], lat);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
